// File: rtl/latch_sched_pkg.sv
// Shared types and helpers for the latch-bank write scheduler.
package latch_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int SETUP_CYC_DEF = 1;
    localparam int OPEN_CYC_DEF  = 1;
    localparam int HOLD_CYC_DEF  = 1;

    // $clog2 that never collapses to a zero-width vector.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/latch_rr_arb2.sv
// Two-requester round-robin arbiter; rr_last names the requester granted most recently.
module latch_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/latch_bank_wr_sched.sv
// Write scheduler for a bank of high-transparent latches: SETUP -> OPEN -> HOLD per write.
// Optional macro LATCH_ADDR_CHECK_EN drops out-of-range writes and pulses err.
module latch_bank_wr_sched
    import latch_sched_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int OPEN_CYC  = OPEN_CYC_DEF,
    parameter int HOLD_CYC  = HOLD_CYC_DEF,
    localparam int AW       = clog2_min1(DEPTH)
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic [WIDTH-1:0] lat_d,
    output logic [DEPTH-1:0] lat_g,
    output logic             busy,
    output logic             err
);

    localparam int MAXC12 = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int MAXC   = (MAXC12 > HOLD_CYC) ? MAXC12 : HOLD_CYC;
    localparam int CW     = clog2_min1(MAXC + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [AW-1:0]    a_r;
    logic             rr_last;
    logic [1:0]       grant;
    logic             accept;
    logic             addr_bad;
    logic [AW-1:0]    acc_addr;
    logic [WIDTH-1:0] acc_data;
    logic [DEPTH-1:0] g_dec, g_nxt;
    logic             err_nxt;

    latch_rr_arb2 u_arb (
        .valid   ({req1_valid, req0_valid}),
        .rr_last (rr_last),
        .grant   (grant)
    );

    // Ready is withheld during reset so nothing looks accepted while RN is low.
    assign req0_ready = RN & (state == IDLE) & grant[0];
    assign req1_ready = RN & (state == IDLE) & grant[1];
    assign accept     = req0_ready | req1_ready;
    assign acc_addr   = grant[1] ? req1_addr : req0_addr;
    assign acc_data   = grant[1] ? req1_data : req0_data;

`ifdef LATCH_ADDR_CHECK_EN
    assign addr_bad = ({1'b0, acc_addr} >= (AW + 1)'(DEPTH));
`else
    assign addr_bad = 1'b0;
`endif

    // An address beyond DEPTH matches no bit, so no latch is ever opened for it.
    always_comb begin
        g_dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            g_dec[i] = (a_r == AW'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        g_nxt     = '0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (addr_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = SETUP;
                        cnt_nxt   = CW'(SETUP_CYC - 1);
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = OPEN;
                    cnt_nxt   = CW'(OPEN_CYC - 1);
                    g_nxt     = g_dec;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            OPEN: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                    g_nxt   = g_dec;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_g   <= '0;
            lat_d   <= '0;
            a_r     <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
            rr_last <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lat_g <= g_nxt;
            busy  <= (state_nxt != IDLE);
            err   <= err_nxt;
            if (accept) begin
                a_r     <= acc_addr;
                lat_d   <= acc_data;
                rr_last <= grant[1];
            end
        end
    end

endmodule
